// File: rtl/pic_interrupt_sequencer.sv
// pic_interrupt_sequencer
// -----------------------------------------------------------------------------
// Interrupt sequencer for an 8259A-style PIC core (8086 mode).
// Resolves rotating priority between the masked request vector from the IRR
// and the In-Service Register held here, raises INT, runs the two-pulse INTA
// acknowledge, reports the acknowledged level back to the IRR, places the
// vector on the data bus and services EOI / rotate-on-EOI commands.
//
// Optional feature macro: PIC_SPURIOUS_IR7_EN
//   defined   : a request that vanishes before the first INTA keeps INT high and
//               the acknowledge completes as a spurious IR7 (no ISR bit set).
//   undefined : a vanished request drops INT and the sequencer returns to idle.
//
// Parameters:
//   SYNC_STAGES   flip-flops synchronising INTA_n before edge detection (>= 2)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   risedBits[7:0] masked requests from the IRR, bit n = IRn
//   INTA_n         CPU interrupt acknowledge, active low, asynchronous
//   vectorBase[4:0] T7..T3 of the vector byte
//   autoEoi        automatic EOI at the end of the acknowledge
//   eoiCmd         one-cycle EOI strobe
//   specificEoi    1 = specific EOI on eoiLevel, 0 = non-specific
//   eoiLevel[2:0]  level for a specific EOI
//   rotateOnEoi    rotate priority so the cleared level becomes lowest
//   INT            interrupt request to the CPU
//   readPriority   one-cycle pulse to the IRR at the first INTA
//   resetIRR[2:0]  IRR level to clear, valid while readPriority = 1
//   isr[7:0]       In-Service Register
//   dataOut[7:0]   vector byte
//   dataOutEnable  drive dataOut onto the bus
// -----------------------------------------------------------------------------
module pic_interrupt_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] risedBits,
    input  logic       INTA_n,
    input  logic [4:0] vectorBase,
    input  logic       autoEoi,
    input  logic       eoiCmd,
    input  logic       specificEoi,
    input  logic [2:0] eoiLevel,
    input  logic       rotateOnEoi,
    output logic       INT,
    output logic       readPriority,
    output logic [2:0] resetIRR,
    output logic [7:0] isr,
    output logic [7:0] dataOut,
    output logic       dataOutEnable
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ACK1 = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_ACK2 = 3'd4;

    // Rank (0 = highest) of the highest-priority set bit, 8 when none is set.
    function automatic logic [3:0] lowest_rank(input logic [7:0] bits,
                                               input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd8;
        for (int r = 7; r >= 0; r--) begin
            lvl = base + 3'(r);
            res = bits[lvl] ? 4'(r) : res;
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   inta_prev_r;
    logic [2:0]             state_r;
    logic [2:0]             id_r;
    logic [2:0]             priority_base_r;
    logic                   spurious_r;

    logic [3:0] win_rank_s;
    logic [3:0] isr_rank_s;
    logic       winner_valid_s;
    logic [2:0] winner_id_s;
    logic [2:0] top_isr_s;
    logic       fall_s;
    logic       rise_s;

    logic       eoi_hit_s;
    logic [2:0] eoi_level_s;
    logic [7:0] eoi_mask_s;

    logic [2:0] state_s;
    logic [2:0] id_s;
    logic       spurious_s;
    logic       int_s;
    logic       read_priority_s;
    logic [2:0] reset_irr_s;
    logic [7:0] data_out_s;
    logic       data_out_enable_s;
    logic [7:0] set_mask_s;
    logic [7:0] aeoi_mask_s;
    logic [7:0] isr_s;
    logic [2:0] priority_base_s;

    // The winner must strictly outrank everything already in service; an
    // empty ISR ranks as 8, so any request wins against it.
    assign win_rank_s     = lowest_rank(risedBits, priority_base_r);
    assign isr_rank_s     = lowest_rank(isr, priority_base_r);
    assign winner_valid_s = (win_rank_s != 4'd8) && (win_rank_s < isr_rank_s);
    assign winner_id_s    = priority_base_r + win_rank_s[2:0];
    assign top_isr_s      = priority_base_r + isr_rank_s[2:0];
    assign fall_s         = inta_prev_r & ~sync_r[SYNC_STAGES-1];
    assign rise_s         = ~inta_prev_r & sync_r[SYNC_STAGES-1];

    // Synchronise INTA_n and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r      <= '0;
            inta_prev_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], INTA_n};
            inta_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Decode the EOI command into the level it clears (if any bit is set there).
    always_comb begin
        eoi_hit_s   = 1'b0;
        eoi_level_s = 3'd0;
        if (eoiCmd) begin
            if (specificEoi) begin
                eoi_level_s = eoiLevel;
                eoi_hit_s   = isr[eoiLevel];
            end else begin
                eoi_level_s = top_isr_s;
                eoi_hit_s   = (isr_rank_s != 4'd8);
            end
        end else begin
            eoi_hit_s = 1'b0;
        end
        eoi_mask_s = eoi_hit_s ? (8'd1 << eoi_level_s) : 8'd0;
    end

    // Acknowledge sequencer next-state and output decode.
    always_comb begin
        state_s           = state_r;
        id_s              = id_r;
        spurious_s        = spurious_r;
        int_s             = INT;
        read_priority_s   = 1'b0;
        reset_irr_s       = resetIRR;
        data_out_s        = dataOut;
        data_out_enable_s = dataOutEnable;
        set_mask_s        = 8'd0;
        aeoi_mask_s       = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (winner_valid_s) begin
                    int_s   = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    int_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (winner_valid_s) begin
                    if (fall_s) begin
                        id_s            = winner_id_s;
                        spurious_s      = 1'b0;
                        set_mask_s      = 8'd1 << winner_id_s;
                        read_priority_s = 1'b1;
                        reset_irr_s     = winner_id_s;
                        int_s           = 1'b0;
                        state_s         = ST_ACK1;
                    end else begin
                        int_s = 1'b1;
                    end
                end else begin
`ifdef PIC_SPURIOUS_IR7_EN
                    // Request vanished: finish the handshake as spurious IR7.
                    if (fall_s) begin
                        id_s       = 3'd7;
                        spurious_s = 1'b1;
                        int_s      = 1'b0;
                        state_s    = ST_ACK1;
                    end else begin
                        int_s = 1'b1;
                    end
`else
                    int_s   = 1'b0;
                    state_s = ST_IDLE;
`endif
                end
            end
            ST_ACK1: begin
                state_s = rise_s ? ST_GAP : ST_ACK1;
            end
            ST_GAP: begin
                if (fall_s) begin
                    data_out_s        = {vectorBase, id_r};
                    data_out_enable_s = 1'b1;
                    state_s           = ST_ACK2;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_ACK2: begin
                if (rise_s) begin
                    data_out_enable_s = 1'b0;
                    aeoi_mask_s       = (autoEoi && !spurious_r) ? (8'd1 << id_r) : 8'd0;
                    state_s           = ST_IDLE;
                end else begin
                    data_out_enable_s = 1'b1;
                end
            end
            default: begin
                state_s           = ST_IDLE;
                int_s             = 1'b0;
                data_out_enable_s = 1'b0;
            end
        endcase
        // A set on the acknowledge edge overrides a clear of the same bit.
        isr_s           = (isr & ~(eoi_mask_s | aeoi_mask_s)) | set_mask_s;
        priority_base_s = (eoi_hit_s && rotateOnEoi) ? (eoi_level_s + 3'd1) : priority_base_r;
    end

    // Register FSM state, ISR, rotation base and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            id_r            <= 3'd0;
            spurious_r      <= 1'b0;
            priority_base_r <= 3'd0;
            INT             <= 1'b0;
            readPriority    <= 1'b0;
            resetIRR        <= 3'd0;
            isr             <= 8'd0;
            dataOut         <= 8'd0;
            dataOutEnable   <= 1'b0;
        end else begin
            state_r         <= state_s;
            id_r            <= id_s;
            spurious_r      <= spurious_s;
            priority_base_r <= priority_base_s;
            INT             <= int_s;
            readPriority    <= read_priority_s;
            resetIRR        <= reset_irr_s;
            isr             <= isr_s;
            dataOut         <= data_out_s;
            dataOutEnable   <= data_out_enable_s;
        end
    end

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// tb_pic_interrupt_sequencer
// Directed scenarios with literal expectations followed by randomized traffic.
// A protocol-level reference model tracks the expected outputs every cycle.
module tb_pic_interrupt_sequencer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] risedBits;
    logic       INTA_n;
    logic [4:0] vectorBase;
    logic       autoEoi;
    logic       eoiCmd;
    logic       specificEoi;
    logic [2:0] eoiLevel;
    logic       rotateOnEoi;
    logic       INT;
    logic       readPriority;
    logic [2:0] resetIRR;
    logic [7:0] isr;
    logic [7:0] dataOut;
    logic       dataOutEnable;

    int tests = 0;
    int fails = 0;

    pic_interrupt_sequencer #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .risedBits(risedBits), .INTA_n(INTA_n),
        .vectorBase(vectorBase), .autoEoi(autoEoi), .eoiCmd(eoiCmd),
        .specificEoi(specificEoi), .eoiLevel(eoiLevel), .rotateOnEoi(rotateOnEoi),
        .INT(INT), .readPriority(readPriority), .resetIRR(resetIRR), .isr(isr),
        .dataOut(dataOut), .dataOutEnable(dataOutEnable)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_WAIT_ACK = 1, P_FIRST_LOW = 2, P_BETWEEN = 3, P_SECOND_LOW = 4;

    logic       m_int, m_rp, m_doe;
    logic [2:0] m_rirr;
    logic [7:0] m_isr, m_dout;
    int         m_base, m_id, phase;
    bit         m_spur;
    logic [S:0] h;   // h[i] = INTA_n sampled i+1 clock edges ago

    task automatic model_reset();
        m_int = 1'b0; m_rp = 1'b0; m_doe = 1'b0; m_rirr = 3'd0;
        m_isr = 8'd0; m_dout = 8'd0; m_base = 0; m_id = 0;
        phase = P_IDLE; m_spur = 1'b0; h = '0;
    endtask

    task automatic model_step();
        int wbest, win, tbest, top, clr_lvl, set_bit;
        bit wvalid, fall, rise, cleared;
        logic [7:0] clr;
        wbest = 8; win = 0; tbest = 8; top = 0;
        for (int n = 0; n < 8; n++) begin
            int rk;
            rk = (n - m_base + 8) % 8;
            if (risedBits[n] && rk < wbest) begin wbest = rk; win = n; end
            if (m_isr[n] && rk < tbest) begin tbest = rk; top = n; end
        end
        wvalid = (wbest < tbest);
        fall = h[S] && !h[S-1];
        rise = !h[S] && h[S-1];
        clr = 8'd0; set_bit = -1; cleared = 1'b0; clr_lvl = 0;
        if (eoiCmd) begin
            if (specificEoi) begin
                if (m_isr[eoiLevel]) begin cleared = 1'b1; clr_lvl = int'(eoiLevel); end
            end else if (tbest < 8) begin
                cleared = 1'b1; clr_lvl = top;
            end
        end
        if (cleared) clr[clr_lvl] = 1'b1;
        m_rp = 1'b0;
        case (phase)
            P_IDLE: if (wvalid) begin m_int = 1'b1; phase = P_WAIT_ACK; end
            P_WAIT_ACK: begin
                if (wvalid && fall) begin
                    m_id = win; set_bit = win; m_rp = 1'b1; m_rirr = 3'(win);
                    m_int = 1'b0; m_spur = 1'b0; phase = P_FIRST_LOW;
                end else if (!wvalid) begin
`ifdef PIC_SPURIOUS_IR7_EN
                    if (fall) begin
                        m_id = 7; m_spur = 1'b1; m_int = 1'b0; phase = P_FIRST_LOW;
                    end
`else
                    m_int = 1'b0; phase = P_IDLE;
`endif
                end
            end
            P_FIRST_LOW: if (rise) phase = P_BETWEEN;
            P_BETWEEN: if (fall) begin
                m_dout = {vectorBase, 3'(m_id)}; m_doe = 1'b1; phase = P_SECOND_LOW;
            end
            P_SECOND_LOW: if (rise) begin
                m_doe = 1'b0;
                if (autoEoi && !m_spur) clr[m_id] = 1'b1;
                phase = P_IDLE;
            end
            default: phase = P_IDLE;
        endcase
        m_isr = m_isr & ~clr;
        if (set_bit >= 0) m_isr[set_bit] = 1'b1;
        if (cleared && rotateOnEoi) m_base = (clr_lvl + 1) % 8;
        h = {h[S-1:0], INTA_n};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output with the model once per cycle, away from the edges.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst_n === 1'b1) begin
                check("INT", int'(INT), int'(m_int));
                check("readPriority", int'(readPriority), int'(m_rp));
                check("resetIRR", int'(resetIRR), int'(m_rirr));
                check("isr", int'(isr), int'(m_isr));
                check("dataOut", int'(dataOut), int'(m_dout));
                check("dataOutEnable", int'(dataOutEnable), int'(m_doe));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
    endtask

    task automatic inta_pulse(input int lo, input int hi, output bit rp, output logic [2:0] rirr);
        rp = 1'b0; rirr = 3'd0;
        INTA_n = 1'b0;
        repeat (lo) begin
            @(negedge clk);
            if (readPriority) begin rp = 1'b1; rirr = resetIRR; end
        end
        INTA_n = 1'b1;
        repeat (hi) begin
            @(negedge clk);
            if (readPriority) begin rp = 1'b1; rirr = resetIRR; end
        end
    endtask

    task automatic do_ack(output bit rp, output logic [2:0] rirr);
        bit rp2; logic [2:0] r2;
        inta_pulse(4, 4, rp, rirr);
        inta_pulse(4, 4, rp2, r2);
    endtask

    bit         rp_seen;
    logic [2:0] rirr_seen;
    int         lat;

    initial begin
        rst_n = 1'b0; risedBits = 8'h04; INTA_n = 1'b1; vectorBase = 5'b01000;
        autoEoi = 1'b0; eoiCmd = 1'b0; specificEoi = 1'b0; eoiLevel = 3'd0; rotateOnEoi = 1'b0;

        // Reset / basic acknowledge
        cyc(3);
        check("rst_INT", int'(INT), 0);
        check("rst_readPriority", int'(readPriority), 0);
        check("rst_isr", int'(isr), 0);
        check("rst_dataOut", int'(dataOut), 0);
        check("rst_dataOutEnable", int'(dataOutEnable), 0);
        rst_n = 1'b1;
        cyc(1);
        check("int_latency", int'(INT), 1);
        cyc(4);
        INTA_n = 1'b0; lat = 0; rirr_seen = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (readPriority && lat == 0) begin lat = i; rirr_seen = resetIRR; end
        end
        INTA_n = 1'b1;
        check("rp_latency", lat, S + 1);
        check("basic_resetIRR", int'(rirr_seen), 2);
        cyc(4);
        check("basic_isr", int'(isr), 8'h04);
        check("model_isr_pin", int'(m_isr), 8'h04);
        check("basic_INT_low", int'(INT), 0);
        INTA_n = 1'b0;
        cyc(5);
        check("basic_doe", int'(dataOutEnable), 1);
        check("basic_vector", int'(dataOut), 8'h42);
        INTA_n = 1'b1;
        cyc(5);
        check("basic_doe_off", int'(dataOutEnable), 0);

        // Priority and nesting
        risedBits = 8'h00; do_reset();
        risedBits = 8'h24; cyc(2);
        do_ack(rp_seen, rirr_seen);
        check("prio_resetIRR", int'(rirr_seen), 2);
        check("prio_isr", int'(isr), 8'h04);
        risedBits = 8'h20; cyc(3);
        check("nest_IR5_blocked", int'(INT), 0);
        risedBits = 8'h21; cyc(2);
        check("nest_IR0_int", int'(INT), 1);
        do_ack(rp_seen, rirr_seen);
        check("nest_resetIRR", int'(rirr_seen), 0);
        check("nest_isr", int'(isr), 8'h05);

        // EOI and rotation
        risedBits = 8'h00; cyc(1);
        eoiCmd = 1'b1; specificEoi = 1'b0; cyc(1); eoiCmd = 1'b0; cyc(1);
        check("ns_eoi_isr", int'(isr), 8'h04);
        eoiCmd = 1'b1; specificEoi = 1'b1; eoiLevel = 3'd2; rotateOnEoi = 1'b1; cyc(1);
        eoiCmd = 1'b0; specificEoi = 1'b0; rotateOnEoi = 1'b0; cyc(1);
        check("sp_eoi_isr", int'(isr), 8'h00);
        check("model_base_pin", m_base, 3);
        risedBits = 8'h05; cyc(2);
        do_ack(rp_seen, rirr_seen);
        check("rot_resetIRR", int'(rirr_seen), 0);
        check("rot_isr", int'(isr), 8'h01);

        // Automatic EOI
        risedBits = 8'h00; do_reset();
        autoEoi = 1'b1; risedBits = 8'h80; cyc(2);
        do_ack(rp_seen, rirr_seen);
        check("aeoi_resetIRR", int'(rirr_seen), 7);
        check("aeoi_isr", int'(isr), 8'h00);
        check("aeoi_vector", int'(dataOut), 8'h47);
        autoEoi = 1'b0;

        // Set on acknowledge collides with specific EOI on the same level
        risedBits = 8'h00; do_reset();
        risedBits = 8'h08; cyc(2);
        INTA_n = 1'b0; cyc(2);
        eoiCmd = 1'b1; specificEoi = 1'b1; eoiLevel = 3'd3; cyc(1);
        eoiCmd = 1'b0; specificEoi = 1'b0;
        check("coll_rp", int'(readPriority), 1);
        check("coll_isr", int'(isr), 8'h08);
        cyc(3); INTA_n = 1'b1; cyc(4); INTA_n = 1'b0; cyc(4); INTA_n = 1'b1; cyc(4);

        // Request vanishes after INT
        risedBits = 8'h00; do_reset();
        risedBits = 8'h02; cyc(2);
        risedBits = 8'h00; cyc(2);
`ifdef PIC_SPURIOUS_IR7_EN
        check("spur_INT_held", int'(INT), 1);
        do_ack(rp_seen, rirr_seen);
        check("spur_no_rp", int'(rp_seen), 0);
        check("spur_vector", int'(dataOut), 8'h47);
        check("spur_isr", int'(isr), 8'h00);
`else
        check("spur_INT_drop", int'(INT), 0);
        do_ack(rp_seen, rirr_seen);
        check("spur_no_rp", int'(rp_seen), 0);
        check("spur_no_doe", int'(dataOutEnable), 0);
        check("spur_dataOut", int'(dataOut), 0);
`endif

        // Randomized traffic
        risedBits = 8'h00; do_reset();
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 10));
            if (r < 3) begin
                risedBits = 8'($urandom);
            end else if (r < 5) begin
                eoiCmd = 1'b1;
                specificEoi = 1'($urandom_range(0, 1));
                eoiLevel = 3'($urandom_range(0, 7));
                rotateOnEoi = 1'($urandom_range(0, 1));
                cyc(1);
                eoiCmd = 1'b0; rotateOnEoi = 1'b0;
            end else if (r < 8) begin
                if (INT || $urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 3) == 0) risedBits = 8'h00;
                    inta_pulse(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), rp_seen, rirr_seen);
                    if ($urandom_range(0, 3) == 0) begin
                        eoiCmd = 1'b1; specificEoi = 1'($urandom_range(0, 1));
                        eoiLevel = 3'($urandom_range(0, 7)); cyc(1); eoiCmd = 1'b0;
                    end
                    inta_pulse(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), rp_seen, rirr_seen);
                end
            end else if (r < 10) begin
                autoEoi = 1'($urandom_range(0, 1));
                vectorBase = 5'($urandom);
            end else begin
                rst_n = 1'b0; cyc(1); rst_n = 1'b1;
            end
            cyc(int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
